// File: rtl/pattern_source_64_pkg.sv
// pattern_source_64_pkg
// Shared definitions for the 64-bit pattern source: mode codes, the
// sequencer state type, the Galois LFSR tap mask and mode helpers.
// Optional feature macro: PATTERN_SOURCE_LFSR_EN (enables mode 4, LFSR).
package pattern_source_64_pkg;

    localparam logic [2:0] MODE_COUNT = 3'd0;
    localparam logic [2:0] MODE_WALK  = 3'd1;
    localparam logic [2:0] MODE_ALT   = 3'd2;
    localparam logic [2:0] MODE_CONST = 3'd3;
    localparam logic [2:0] MODE_LFSR  = 3'd4;

    localparam logic [63:0] ALT_FIRST = 64'hAAAA_AAAA_AAAA_AAAA;

    // Right-shifting Galois form of taps 64,63,61,60: bits 63,62,60,59.
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEED = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // A mode code with no generator behind it in this build.
    function automatic logic mode_reserved(input logic [2:0] mode);
`ifdef PATTERN_SOURCE_LFSR_EN
        return (mode > MODE_LFSR);
`else
        return (mode > MODE_CONST);
`endif
    endfunction

    // Reserved codes run the counter.
    function automatic logic [2:0] effective_mode(input logic [2:0] mode);
        return mode_reserved(mode) ? MODE_COUNT : mode;
    endfunction

endpackage

// File: rtl/pattern_source_64_lfsr64_step.sv
// lfsr64_step
// One step of the 64-bit Galois LFSR (taps 64,63,61,60), purely
// combinational.
//   state_in  : current LFSR value
//   state_out : value after one shift
module lfsr64_step
    import pattern_source_64_pkg::*;
(
    input  logic [63:0] state_in,
    output logic [63:0] state_out
);

    assign state_out = state_in[0] ? ((state_in >> 1) ^ LFSR_TAPS)
                                   : (state_in >> 1);

endmodule

// File: rtl/pattern_source_64.sv
// pattern_source_64
// Generates 64-bit test words for a FIFO writer. After reset the
// sequencer passes IDLE -> SEED -> RUN; SEED latches the pattern word and
// loads the generator with the mode's first word. In RUN each cycle with
// enable_gener emits the generator word (one cycle later, with a strobe)
// and advances the generator. A change of pattern in RUN forces a reseed.
// Optional feature macro: PATTERN_SOURCE_LFSR_EN (mode 4 = Galois LFSR;
// when undefined mode 4 is reserved like codes 5-7).
// Ports:
//   okClk             : clock, rising edge
//   reset             : synchronous active-high reset
//   pattern[31:0]     : [2:0] mode, [31:8] seed/constant
//   enable_gener      : emit one word this cycle
//   dataout[63:0]     : registered generated word
//   dataout_available : one-cycle strobe, dataout valid
//   word_count[31:0]  : words emitted since reset/reseed
//   pattern_error     : sticky, reserved mode was seeded
// Handshake: there is no back-pressure; enable_gener is a one-sided
// request and every accepted request produces exactly one strobe on the
// following cycle.
module pattern_source_64
    import pattern_source_64_pkg::*;
(
    input  logic        okClk,
    input  logic        reset,
    input  logic [31:0] pattern,
    input  logic        enable_gener,
    output logic [63:0] dataout,
    output logic        dataout_available,
    output logic [31:0] word_count,
    output logic        pattern_error
);

    state_t      state_q, state_d;
    logic        do_seed, do_emit;
    logic [31:0] pat_q;
    logic [63:0] gen_q;       // next word to be emitted
    logic [63:0] seed_word;
    logic [63:0] step_word;
    logic [2:0]  seed_mode;
    logic [2:0]  run_mode;

    // ---------------- sequencer ----------------
    always_ff @(posedge okClk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        do_seed = 1'b0;
        do_emit = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_SEED;
            ST_SEED: begin
                do_seed = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // A pattern change wins over enable: the old sequence
                // must not leak a word after the mode was changed.
                if (pattern != pat_q)  state_d = ST_SEED;
                else if (enable_gener) do_emit = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- generator ----------------
    assign seed_mode = effective_mode(pattern[2:0]);
    assign run_mode  = effective_mode(pat_q[2:0]);

`ifdef PATTERN_SOURCE_LFSR_EN
    logic [63:0] lfsr_next;

    lfsr64_step u_lfsr (
        .state_in  (gen_q),
        .state_out (lfsr_next)
    );
`endif

    always_comb begin
        seed_word = '0;
        case (seed_mode)
            MODE_WALK:  seed_word = 64'h1;
            MODE_ALT:   seed_word = ALT_FIRST;
            MODE_CONST: seed_word = {40'h0, pattern[31:8]};
`ifdef PATTERN_SOURCE_LFSR_EN
            // An all-zero LFSR would lock up; substitute 1.
            MODE_LFSR:  seed_word = (pattern[31:8] == 24'h0) ? 64'h1
                                                             : {40'h0, pattern[31:8]};
`endif
            default:    seed_word = '0;
        endcase
    end

    always_comb begin
        step_word = gen_q + 64'h1;
        case (run_mode)
            MODE_WALK:  step_word = {gen_q[62:0], gen_q[63]};
            MODE_ALT:   step_word = ~gen_q;
            MODE_CONST: step_word = gen_q;
`ifdef PATTERN_SOURCE_LFSR_EN
            MODE_LFSR:  step_word = lfsr_next;
`endif
            default:    step_word = gen_q + 64'h1;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge okClk) begin
        if (reset) begin
            pat_q             <= '0;
            gen_q             <= '0;
            dataout           <= '0;
            dataout_available <= 1'b0;
            word_count        <= '0;
            pattern_error     <= 1'b0;
        end else begin
            dataout_available <= do_emit;
            if (do_seed) begin
                pat_q      <= pattern;
                gen_q      <= seed_word;
                word_count <= '0;
                if (mode_reserved(pattern[2:0])) pattern_error <= 1'b1;
            end
            if (do_emit) begin
                dataout    <= gen_q;
                gen_q      <= step_word;
                word_count <= word_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pattern_source_64.sv
// tb_pattern_source_64
// Bench for pattern_source_64: directed scenarios with literal expected
// words plus a randomized phase, all outputs compared every cycle against
// a behavioural model that derives each word from its index in the
// sequence.
module tb_pattern_source_64;

    logic        okClk = 1'b0;
    logic        reset;
    logic [31:0] pattern;
    logic        enable_gener;
    logic [63:0] dataout;
    logic        dataout_available;
    logic [31:0] word_count;
    logic        pattern_error;

    int n_checks = 0;
    int n_bad    = 0;

`ifdef PATTERN_SOURCE_LFSR_EN
    localparam bit LFSR_BUILT = 1'b1;
`else
    localparam bit LFSR_BUILT = 1'b0;
`endif

    pattern_source_64 dut (
        .okClk             (okClk),
        .reset             (reset),
        .pattern           (pattern),
        .enable_gener      (enable_gener),
        .dataout           (dataout),
        .dataout_available (dataout_available),
        .word_count        (word_count),
        .pattern_error     (pattern_error)
    );

    // ---------------- clock ----------------
    always #5 okClk = ~okClk;

    // ---------------- checker ----------------
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_wait;      // cycles left before words may flow (2 = just reset)
    logic [31:0] m_pat;
    logic [2:0]  m_mode;
    logic [63:0] m_n;         // index of next word in the sequence
    logic [63:0] m_lfsr;
    logic [63:0] e_data  = '0;
    logic        e_avail = 1'b0;
    logic [31:0] e_wc    = '0;
    logic        e_err   = 1'b0;

    function automatic logic [63:0] lfsr_step(input logic [63:0] x);
        logic [63:0] mask;
        mask = (64'h1 << 63) | (64'h1 << 62) | (64'h1 << 60) | (64'h1 << 59);
        return x[0] ? ((x >> 1) ^ mask) : (x >> 1);
    endfunction

    function automatic logic [63:0] word_at();
        case (m_mode)
            3'd1:    return 64'h1 << m_n[5:0];
            3'd2:    return m_n[0] ? 64'h5555_5555_5555_5555 : 64'hAAAA_AAAA_AAAA_AAAA;
            3'd3:    return {40'h0, m_pat[31:8]};
            3'd4:    return m_lfsr;
            default: return m_n;
        endcase
    endfunction

    always @(posedge okClk) begin
        if (reset) begin
            m_wait = 2; e_data = '0; e_avail = 1'b0; e_wc = '0; e_err = 1'b0;
        end else begin
            e_avail = 1'b0;
            if (m_wait == 2) begin
                m_wait = 1;
            end else if (m_wait == 1) begin
                logic reserved;
                reserved = (pattern[2:0] > 3'd4) || (pattern[2:0] == 3'd4 && !LFSR_BUILT);
                m_pat  = pattern;
                m_mode = reserved ? 3'd0 : pattern[2:0];
                m_n    = '0;
                m_lfsr = (pattern[31:8] == 24'h0) ? 64'h1 : {40'h0, pattern[31:8]};
                e_wc   = '0;
                e_err  = e_err | reserved;
                m_wait = 0;
            end else if (pattern != m_pat) begin
                m_wait = 1;
            end else if (enable_gener) begin
                e_data  = word_at();
                e_avail = 1'b1;
                m_n     = m_n + 64'h1;
                m_lfsr  = lfsr_step(m_lfsr);
                e_wc    = e_wc + 32'd1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];

    always @(negedge okClk) begin
        check_val("avail", {63'h0, dataout_available}, {63'h0, e_avail});
        check_val("data", dataout, e_data);
        check_val("word_count", {32'h0, word_count}, {32'h0, e_wc});
        check_val("pattern_error", {63'h0, pattern_error}, {63'h0, e_err});
        if (dataout_available) got_q.push_back(dataout);
    end

    task automatic compare_words(input string tag);
        check_val({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            check_val(tag, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic en);
        enable_gener = en;
        @(negedge okClk);
    endtask

    task automatic set_pattern(input logic [31:0] p);
        pattern      = p;
        enable_gener = 1'b0;
        repeat (2) @(negedge okClk);   // mismatch cycle, then SEED
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge okClk);
        reset = 1'b0;
        repeat (2) @(negedge okClk);   // IDLE, SEED
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset        = 1'b1;
        pattern      = 32'h0;
        enable_gener = 1'b0;
        repeat (2) @(negedge okClk);
        check_val("rst_data", dataout, 64'h0);
        check_val("rst_wc", {32'h0, word_count}, 64'h0);
        reset = 1'b0;
        repeat (2) @(negedge okClk);

        // counter: 0..4
        got_q.delete();
        repeat (5) step(1'b1);
        step(1'b0);
        for (int i = 0; i < 5; i++) exp_q.push_back(64'(i));
        compare_words("counter");
        check_val("counter_wc", {32'h0, word_count}, 64'd5);

        // walking one with a gap
        set_pattern(32'h1);
        got_q.delete();
        step(1'b1);
        step(1'b0);
        check_val("walk_hold", dataout, 64'h1);
        step(1'b1);
        step(1'b0);
        exp_q.push_back(64'h1);
        exp_q.push_back(64'h2);
        compare_words("walk");

        // constant, then reseed to alternating with enable held high
        set_pattern(32'h0012_3403);
        got_q.delete();
        step(1'b1);
        step(1'b1);
        pattern = 32'h2;
        @(negedge okClk);
        check_val("reseed_nostrobe", {63'h0, dataout_available}, 64'h0);
        @(negedge okClk);
        check_val("reseed_wc", {32'h0, word_count}, 64'h0);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        exp_q.push_back(64'h0000_0000_0000_1234);
        exp_q.push_back(64'h0000_0000_0000_1234);
        exp_q.push_back(64'hAAAA_AAAA_AAAA_AAAA);
        exp_q.push_back(64'h5555_5555_5555_5555);
        compare_words("const_alt");

        // mode 4
        set_pattern(32'h4);
        got_q.delete();
        step(1'b1);
        step(1'b1);
        step(1'b0);
        if (LFSR_BUILT) begin
            exp_q.push_back(64'h1);
            exp_q.push_back(64'hD800_0000_0000_0000);
        end else begin
            exp_q.push_back(64'h0);
            exp_q.push_back(64'h1);
        end
        compare_words("mode4");
        check_val("mode4_err", {63'h0, pattern_error}, LFSR_BUILT ? 64'h0 : 64'h1);

        // reset mid-run after 3 counter words
        set_pattern(32'h0);
        repeat (3) step(1'b1);
        reset = 1'b1;
        @(negedge okClk);
        check_val("midrst_avail", {63'h0, dataout_available}, 64'h0);
        check_val("midrst_data", dataout, 64'h0);
        check_val("midrst_err", {63'h0, pattern_error}, 64'h0);
        reset        = 1'b0;
        enable_gener = 1'b0;
        repeat (2) @(negedge okClk);
        got_q.delete();
        step(1'b1);
        step(1'b0);
        exp_q.push_back(64'h0);
        compare_words("after_reset");

        // counter and word_count wrap
        #2;
        force dut.gen_q      = 64'hFFFF_FFFF_FFFF_FFFE;
        force dut.word_count = 32'hFFFF_FFFF;
        m_n  = 64'hFFFF_FFFF_FFFF_FFFE;
        e_wc = 32'hFFFF_FFFF;
        #1;
        release dut.gen_q;
        release dut.word_count;
        @(negedge okClk);
        got_q.delete();
        step(1'b1);
        check_val("wrap_wc", {32'h0, word_count}, 64'h0);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        exp_q.push_back(64'h0);
        compare_words("wrap");

        // randomized phase, checked every cycle by the model
        for (int i = 0; i < 600; i++) begin
            enable_gener = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0)
                pattern = {$urandom_range(0, 255) == 0 ? 24'h0 : 24'($urandom()),
                           5'($urandom()), 3'($urandom_range(0, 7))};
            reset = ($urandom_range(0, 99) == 0);
            @(negedge okClk);
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/pattern_source_64.md
PATTERN_SOURCE_64 -- requirements
Module: pattern_source_64

Interface
REQ-001 SHALL have port okClk  input  1  system clock; all logic is on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset on okClk.
REQ-003 SHALL have port pattern  input  32  mode in [2:0]; seed/constant in [31:8]; quasi-static, from a wire-in.
REQ-004 SHALL have port enable_gener  input  1  request to emit one word this cycle (timer_on & ~almost_full upstream of FIFO).
REQ-005 SHALL have port dataout  output  64  generated word, registered.
REQ-006 SHALL have port dataout_available  output  1  one-cycle strobe; dataout is valid and is to be written to the FIFO.
REQ-007 SHALL have port word_count  output  32  words emitted since reset or last reseed.
REQ-008 SHALL have port pattern_error  output  1  sticky; a reserved mode code was selected.

Function
REQ-009 SHALL implement state machine IDLE -> SEED -> RUN.
- IDLE to SEED on the first cycle after reset.
- SEED lasts exactly 1 cycle: latches pattern and loads the generator state.
- Then to RUN.
REQ-010 SHALL, in RUN, return to SEED on any cycle where pattern differs from the latched copy; no word is emitted during that SEED cycle.
REQ-011 SHALL, in RUN with enable_gener=1 at edge N, drive dataout_available=1 and the next word on dataout after edge N (1-cycle latency); otherwise dataout_available=0 and dataout holds.
REQ-012 SHALL advance the generator state only on emitted words; no words are skipped or duplicated across enable gaps.
REQ-013 SHALL support mode 0 (counter): first word 0, then +1 per word; wraps 64'hFFFF_FFFF_FFFF_FFFF -> 0.
REQ-014 SHALL support mode 1 (walking one): first word 64'h1, rotate left by 1 per word; bit 63 wraps to bit 0.
REQ-015 SHALL support mode 2 (alternating): first word 64'hAAAA_AAAA_AAAA_AAAA, then 64'h5555_5555_5555_5555, alternating.
REQ-016 SHALL support mode 3 (constant): every word is {40'h0, pattern[31:8]}.
REQ-017 SHALL support mode 4 (LFSR, see Configuration): 64-bit Galois LFSR, taps 64,63,61,60, advancing 1 step per word.
- Seed {40'h0, pattern[31:8]}; 64'h1 if that value is 0.
- First word emitted = seed.
REQ-018 SHALL treat codes 5-7 (and 4 when LFSR is compiled out) as reserved: behave as mode 0 and set pattern_error.
REQ-019 SHALL increment word_count on every emitted word, wrap 32'hFFFF_FFFF -> 0, and clear it to 0 in SEED.
REQ-020 SHALL ignore enable_gener in IDLE and SEED.

Reset
REQ-021 SHALL, on reset=1, set state=IDLE, dataout=0, dataout_available=0, word_count=0, pattern_error=0, and clear the generator state in the same cycle.
REQ-022 SHALL give reset priority over enable_gener and pattern change.
REQ-023 SHALL, on reset asserted mid-RUN, suppress any strobe on the following cycle and restart from the mode's first word after reseeding.

Configuration
REQ-024 SHALL compile the LFSR mode in only when macro PATTERN_SOURCE_LFSR_EN is defined.
- Defined: mode 4 behaves as REQ-017.
- Undefined: no LFSR logic is present; mode 4 is reserved per REQ-018.

Structure
REQ-025 SHALL place in the shared package:
- mode code constants (MODE_COUNT=0, MODE_WALK=1, MODE_ALT=2, MODE_CONST=3, MODE_LFSR=4)
- state enum
- the LFSR tap constant
REQ-026 SHALL isolate the LFSR in sub-module lfsr64_step (combinational next-state function), instantiated only under PATTERN_SOURCE_LFSR_EN.

Verification
REQ-027 SHALL cover counter mode: pattern=0, enable high 5 cycles after RUN -> dataout 0,1,2,3,4, with 5 strobes; word_count=5.
REQ-028 SHALL cover walking one with gaps: pattern=1, enable pattern 1,0,1 -> words 64'h1 then 64'h2, with 2 strobes; dataout holds 64'h1 during the gap.
REQ-029 SHALL cover constant and reseed: pattern=32'h0012_3403 -> words 64'h0000_0000_0000_1234; change to pattern=2 mid-run -> no strobe for 1 cycle, word_count=0, then 64'hAAAA..., 64'h5555....
REQ-030 SHALL cover LFSR: with macro defined and pattern=4 -> first word 64'h1, second word = one Galois step of 64'h1; without macro -> mode-0 sequence and pattern_error=1.
REQ-031 SHALL cover reset mid-run: reset pulsed after 3 counter words -> outputs zero on the next cycle; after reseed the first word is 0 again.
REQ-032 SHALL cover wrap: force the counter to 64'hFFFF_FFFF_FFFF_FFFE and word_count to 32'hFFFF_FFFF -> words ...FE, ...FF, 0; word_count wraps to 0.
